// File: rtl/common_dffram_fifo_ctrl_pkg.sv
// Shared types for the DFF-RAM FIFO controller.
// Defines the single-port RAM operation selected each cycle.
// No logic lives here; the controller imports these names.
package common_dffram_fifo_ctrl_pkg;

    // One RAM access per cycle at most: idle, head refill, or store of a push.
    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_READ  = 2'd1,
        RAM_WRITE = 2'd2
    } ram_op_e;

endpackage

// File: rtl/common_dffram_fifo_ctrl.sv
// Valid/ready FIFO built from a single-port DFF RAM plus a registered head stage.
// Latency: push into an empty FIFO shows on pop_valid next cycle; RAM entries reach the head one cycle after refill.
// Backpressure: a head refill owns the RAM port, so push_ready drops that cycle (comb path from pop_ready to push_ready).
module common_dffram_fifo_ctrl
    import common_dffram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LVL_W = ADDR_WIDTH + 2;

    // Controller state: RAM pointers, RAM-resident count, and the head stage.
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_head_vld;
    logic [DATA_WIDTH-1:0] r_head_dat;

    // Per-cycle decisions.
    logic    w_cnt_zero;
    logic    w_cnt_full;
    logic    w_head_free;
    logic    w_pop_fire;
    logic    w_refill;
    logic    w_push_rdy;
    logic    w_push_fire;
    logic    w_bypass;
    logic    w_write;
    ram_op_e w_ram_op;

    // Derive refill/bypass/write; a refill always takes the port ahead of a push.
    always_comb begin
        w_cnt_zero  = (r_cnt == '0);
        w_cnt_full  = (r_cnt == CNT_W'(DEPTH));
        w_head_free = !r_head_vld | pop_ready;
        w_pop_fire  = r_head_vld & pop_ready;
        w_refill    = !w_cnt_zero & w_head_free & !flush;
        // reset gates the ready so nothing is accepted while the block is held in reset
        w_push_rdy  = reset & !flush & !w_refill & !w_cnt_full;
        w_push_fire = push_valid & w_push_rdy;
        // bypass only when the RAM is empty, so the head is never younger than RAM data
        w_bypass    = w_push_fire & w_cnt_zero & w_head_free;
        w_write     = w_push_fire & !w_bypass;
    end

    // Select the single RAM operation for this cycle.
    always_comb begin
        w_ram_op = RAM_IDLE;
        if (w_refill) begin
            w_ram_op = RAM_READ;
        end else if (w_write) begin
            w_ram_op = RAM_WRITE;
        end
    end

    // Drive the RAM port from the selected operation.
    always_comb begin
        ram_en   = (w_ram_op != RAM_IDLE);
        ram_we   = (w_ram_op == RAM_WRITE);
        ram_addr = (w_ram_op == RAM_READ) ? r_rd_ptr : r_wr_ptr;
        ram_din  = push_data;
    end

    // Pointer and count bookkeeping; refill and write never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            // RAM contents are left stale; only the bookkeeping is cleared
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_refill) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_cnt    <= r_cnt - CNT_W'(1);
        end else if (w_write) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Head stage: load from RAM on refill, from the producer on bypass, empty on a bare pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head_vld <= 1'b0;
            r_head_dat <= '0;
        end else if (flush) begin
            r_head_vld <= 1'b0;
        end else if (w_refill) begin
            r_head_vld <= 1'b1;
            r_head_dat <= ram_dout;
        end else if (w_bypass) begin
            r_head_vld <= 1'b1;
            r_head_dat <= push_data;
        end else if (w_pop_fire) begin
            r_head_vld <= 1'b0;
        end
    end

    // Outputs; level depends only on registered state.
    always_comb begin
        push_ready = w_push_rdy;
        pop_valid  = r_head_vld;
        pop_data   = r_head_dat;
        level      = LVL_W'(r_cnt) + LVL_W'(r_head_vld);
    end

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Directed bench for the DFF-RAM FIFO controller with a behavioural single-port RAM.
// Stimulus steps record accepted pushes in a queue; a negedge monitor checks every pop against it.
// Per-cycle RAM port and ready values come from hand-computed tables.
module tb_common_dffram_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       push_valid;
    logic       push_ready;
    logic [7:0] push_data;
    logic       pop_valid;
    logic       pop_ready;
    logic [7:0] pop_data;
    logic [3:0] level;
    logic [1:0] ram_addr;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [4];
    logic [7:0] exp_q [$];
    int         n_checks;
    int         n_pass;

    common_dffram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .level      (level),
        .ram_addr   (ram_addr),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DFF RAM: synchronous write, combinational read.
    initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted pop must match the oldest accepted push.
    always @(negedge clk) begin
        if (reset === 1'b1 && flush === 1'b0 && pop_valid === 1'b1 && pop_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(pop_data), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive inputs, check comb port values mid-cycle, record accepted push, advance.
    task automatic step(input logic pv, input logic [7:0] pd, input logic pr, input logic fl,
                        input logic e_prdy, input logic e_en, input logic e_we,
                        input logic [1:0] e_addr, input string tag);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        @(negedge clk);
        check({tag, ".push_ready"}, 32'(push_ready), 32'(e_prdy));
        check({tag, ".ram_en"}, 32'(ram_en), 32'(e_en));
        if (e_en) begin
            check({tag, ".ram_we"}, 32'(ram_we), 32'(e_we));
            check({tag, ".ram_addr"}, 32'(ram_addr), 32'(e_addr));
        end
        if (pv) check({tag, ".ram_din"}, 32'(ram_din), 32'(pd));
        if (pv && e_prdy && !fl) exp_q.push_back(pd);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input logic e_vld, input logic [7:0] e_dat, input logic chk_dat,
                               input logic [3:0] e_lvl, input string tag);
        check({tag, ".pop_valid"}, 32'(pop_valid), 32'(e_vld));
        if (chk_dat) check({tag, ".pop_data"}, 32'(pop_data), 32'(e_dat));
        check({tag, ".level"}, 32'(level), 32'(e_lvl));
    endtask

    // Rate-matched phase starting from cnt=2, wr_ptr=2, rd_ptr=0; pop_ready alternates.
    localparam int NR = 9;
    logic       rt_pv   [NR] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0] rt_pd   [NR] = '{8'h24, 8'h24, 8'h25, 8'h25, 8'h26, 8'h26, 8'h00, 8'h00, 8'h00};
    logic       rt_pr   [NR] = '{1, 0, 1, 0, 1, 0, 1, 1, 1};
    logic       rt_prdy [NR] = '{0, 1, 0, 1, 0, 1, 0, 0, 1};
    logic       rt_en   [NR] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic       rt_we   [NR] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
    logic [1:0] rt_addr [NR] = '{0, 2, 1, 3, 2, 0, 3, 0, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        #2;
        check("in_reset.push_ready", 32'(push_ready), 32'd0);
        check_state(1'b0, 8'h00, 1'b1, 4'd0, "in_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset release.
        check_state(1'b0, 8'h00, 1'b1, 4'd0, "idle");
        step(0, 8'h00, 0, 0, 1, 0, 0, 0, "idle");

        // Bypass into empty FIFO, then fill the RAM.
        step(1, 8'h11, 0, 0, 1, 0, 0, 0, "bypass11");
        check_state(1'b1, 8'h11, 1'b1, 4'd1, "after11");
        step(1, 8'h12, 0, 0, 1, 1, 1, 0, "wr12");
        step(1, 8'h13, 0, 0, 1, 1, 1, 1, "wr13");
        step(1, 8'h14, 0, 0, 1, 1, 1, 2, "wr14");
        step(1, 8'h15, 0, 0, 1, 1, 1, 3, "wr15");
        check_state(1'b1, 8'h11, 1'b1, 4'd5, "full");
        step(1, 8'h16, 0, 0, 0, 0, 0, 0, "stall16");
        check_state(1'b1, 8'h11, 1'b1, 4'd5, "still_full");

        // Drain from full: refills from addr 0..3, last pop needs no refill.
        for (int k = 0; k < 5; k++) begin
            check("drain.level", 32'(level), 32'(5 - k));
            step(0, 8'h00, 1, 0, (k == 4), (k < 4), 0, 2'(k), "drain");
        end
        check_state(1'b0, 8'h00, 1'b0, 4'd0, "drained");
        step(0, 8'h00, 1, 0, 1, 0, 0, 0, "empty_pop");
        check_state(1'b0, 8'h00, 1'b0, 4'd0, "empty_after");

        // Build cnt=2 (head + two RAM entries), then rate-matched push/pop with wrap.
        step(1, 8'h21, 0, 0, 1, 0, 0, 0, "b21");
        step(1, 8'h22, 0, 0, 1, 1, 1, 0, "w22");
        step(1, 8'h23, 0, 0, 1, 1, 1, 1, "w23");
        check_state(1'b1, 8'h21, 1'b1, 4'd3, "cnt2");
        for (int k = 0; k < NR; k++) begin
            step(rt_pv[k], rt_pd[k], rt_pr[k], 0, rt_prdy[k], rt_en[k], rt_we[k], rt_addr[k], "rate");
        end
        check_state(1'b0, 8'h00, 1'b0, 4'd0, "rate_done");

        // Flush at level 3 with a push offered.
        step(1, 8'h31, 0, 0, 1, 0, 0, 0, "b31");
        step(1, 8'h32, 0, 0, 1, 1, 1, 1, "w32");
        step(1, 8'h33, 0, 0, 1, 1, 1, 2, "w33");
        check_state(1'b1, 8'h31, 1'b1, 4'd3, "pre_flush");
        step(1, 8'h99, 1, 1, 0, 0, 0, 0, "flush");
        exp_q.delete();
        check_state(1'b0, 8'h00, 1'b0, 4'd0, "post_flush");
        step(1, 8'hAA, 0, 0, 1, 0, 0, 0, "bAA");
        check_state(1'b1, 8'hAA, 1'b1, 4'd1, "afterAA");
        step(0, 8'h00, 1, 0, 1, 0, 0, 0, "popAA");
        check_state(1'b0, 8'h00, 1'b0, 4'd0, "emptyAA");

        // Asynchronous reset mid-operation.
        step(1, 8'h55, 0, 0, 1, 0, 0, 0, "b55");
        step(1, 8'h56, 0, 0, 1, 1, 1, 0, "w56");
        check_state(1'b1, 8'h55, 1'b1, 4'd2, "pre_reset");
        push_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset.push_ready", 32'(push_ready), 32'd0);
        check_state(1'b0, 8'h00, 1'b1, 4'd0, "mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 8'h00, 1, 0, 1, 0, 0, 0, "post_reset");
        check("final.queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/common_dffram_fifo_ctrl.md
Name: common_dffram_fifo_ctrl

Overview:
- Initiator-side controller for the team's single-address DFF RAM: it owns that RAM's single addr/en/we/din port and consumes its combinational dout.
- It builds a valid/ready FIFO from the RAM plus one registered output stage (head register). Total capacity is 2^ADDR_WIDTH + 1.
- It serialises writes (pushes) and head refills (RAM reads) onto the one address port.
- Used wherever the core needs a small buffered queue: fetch buffers, writeback queues.

Parameters:
- DATA_WIDTH, 8, width of each entry.
- ADDR_WIDTH, 2, RAM address width; RAM depth DEPTH = 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- push_valid  in  1  producer offers push_data.
- push_ready  out  1  controller accepts push this cycle.
- push_data  in  DATA_WIDTH  entry to enqueue.
- pop_valid  out  1  head register holds valid data.
- pop_ready  in  1  consumer takes head this cycle.
- pop_data  out  DATA_WIDTH  head entry (registered).
- level  out  ADDR_WIDTH+2  total occupancy, 0..DEPTH+1.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_din  out  DATA_WIDTH  RAM write data (always equals push_data).
- ram_dout  in  DATA_WIDTH  RAM read data, combinational from ram_addr.

Behaviour:
- State:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits; wrap modulo DEPTH naturally.
  - cnt: ADDR_WIDTH+1 bits, RAM-resident entries, 0..DEPTH.
  - head_valid, head_data: the output stage.
- Reset (reset low, asynchronous): pointers=0, cnt=0, head_valid=0, head_data=0. Hence pop_valid=0, pop_data=0, level=0, push_ready=0 while reset is asserted.
- Derived signals:
  - pop_fire = pop_valid & pop_ready.
  - head_free = !head_valid | pop_ready.
  - refill = (cnt!=0) & head_free & !flush.
  - push_ready = !flush & !refill & (cnt!=DEPTH).
  - push_fire = push_valid & push_ready.
  - bypass = push_fire & (cnt==0) & head_free.
  - write = push_fire & !bypass.
- Port priority: a read (refill) wins over a write. push_ready therefore has a combinational path from pop_ready; this is intended and documented for integrators.
- RAM port:
  - ram_addr = refill ? rd_ptr : wr_ptr.
  - ram_en = refill | write.
  - ram_we = write.
  - At most one RAM access per cycle.
- Refill: head_data <= ram_dout, head_valid <= 1, rd_ptr++, cnt--. Latency: a RAM entry reaches pop_data the cycle after refill.
- Bypass: head_data <= push_data, head_valid <= 1, no RAM access. An empty FIFO presents pushed data on pop_valid the next cycle (1-cycle latency).
- Write: stores at wr_ptr, then wr_ptr++, cnt++.
- Pop without refill or bypass: head_valid <= 0.
- Ordering: FIFO order is strict. Bypass only occurs when cnt==0, so the RAM never holds older data than the head.
- level = cnt + head_valid, registered-state derived, no comb input path.
- Full: cnt==DEPTH, so push_ready=0. If the head is free, refill runs that cycle and push_ready returns the next cycle.
- Empty with pop_ready=1 and no push: pop_valid stays 0; no RAM access.
- Simultaneous push+pop with cnt>0: refill wins; the push stalls one cycle. Sustained throughput is 1 entry per 2 cycles when the RAM is non-empty and both sides are active. This is accepted for a minimal-area design.
- Simultaneous push+pop with cnt==0 and head valid: bypass; the head is replaced by push_data; level is unchanged.
- flush: next cycle pointers=0, cnt=0, head_valid=0. Push and pop in the flush cycle are ignored (push_ready=0; pop_fire has no effect). The RAM contents are left stale, which is harmless.
- Reset mid-operation: immediate return to the reset state; in-flight data is lost.

Decomposition:
- No shared package required; DEPTH and the cnt/level widths are local parameters derived from ADDR_WIDTH.
- No sub-module: the RAM is instantiated by the parent and connected via the ram_* ports, so the controller stays reusable across RAM implementations.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, capacity 5):
- Reset release, idle -> pop_valid=0, pop_data=0x00, level=0, push_ready=1, ram_en=0.
- Push 0x11 into empty FIFO with pop_ready=0 -> no RAM access (bypass); next cycle pop_valid=1, pop_data=0x11, level=1.
- Push 0x11..0x15 with pop_ready=0 -> 0x12..0x15 written at addr 0..3; level=5; push_ready=0; 6th push stalls.
- From full, hold pop_ready=1 for 5 cycles -> pops 0x11,0x12,0x13,0x14,0x15 in order, refills from addr 0..3; level reaches 0; pop_valid=0 after.
- Full-rate push+pop with cnt=2 -> refill takes the port and push_ready=0 that cycle; the stalled entry is written next cycle; order preserved; wr_ptr wraps 3->0 correctly.
- flush with level=3 and push_valid=1 -> push_ready=0; next cycle level=0, pop_valid=0; subsequent push 0xAA bypasses and appears next cycle.
